// File: rtl/ux607_aon_scaled_counter_pkg.sv
// Shared perips constants for the always-on scaled counter and its config register vector.
package ux607_aon_scaled_counter_pkg;

   // Default widths of the counter datapath
   localparam int unsigned CNT_W_DEF   = 31;
   localparam int unsigned CMP_W_DEF   = 16;
   localparam int unsigned SCALE_W_DEF = 3;

   // Bit positions inside the 5-bit config vector {en_oneshot, en_always, scale[2:0]}
   localparam int unsigned CFG_W          = 5;
   localparam int unsigned CFG_SCALE_LSB  = 0;
   localparam int unsigned CFG_SCALE_MSB  = 2;
   localparam int unsigned CFG_EN_ALWAYS  = 3;
   localparam int unsigned CFG_EN_ONESHOT = 4;

endpackage : ux607_aon_scaled_counter_pkg

// File: rtl/ux607_aon_scale_mux.sv
// Combinational scale select: returns count[scale +: CMP_W], zero-filled above the counter MSB.
module ux607_aon_scale_mux
   import ux607_aon_scaled_counter_pkg::*;
#(
   parameter int unsigned CNT_W   = CNT_W_DEF,
   parameter int unsigned CMP_W   = CMP_W_DEF,
   parameter int unsigned SCALE_W = SCALE_W_DEF
) (
   input  logic [CNT_W-1:0]   i_count,
   input  logic [SCALE_W-1:0] i_scale,
   output logic [CMP_W-1:0]   o_scaled_c
);

   // Zero-extended so a window reaching past the counter MSB reads zeros
   logic [CNT_W+CMP_W-1:0] w_ext;

   assign w_ext      = {CMP_W'(0), i_count};
   assign o_scaled_c = CMP_W'(w_ext >> i_scale);

endmodule : ux607_aon_scale_mux

// File: rtl/ux607_aon_scaled_counter.sv
// Always-on scaled counter with compare, sticky interrupt and oneshot-enable clear pulse.
module ux607_aon_scaled_counter
   import ux607_aon_scaled_counter_pkg::*;
#(
   parameter int unsigned CNT_W   = CNT_W_DEF,
   parameter int unsigned CMP_W   = CMP_W_DEF,
   parameter int unsigned SCALE_W = SCALE_W_DEF
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [SCALE_W-1:0] cfg_scale,
   input  logic               cfg_en_always,
   input  logic               cfg_en_oneshot,
   input  logic               cfg_zero_cmp,
   input  logic               cnt_wr_en,
   input  logic [CNT_W-1:0]   cnt_wr_data,
   input  logic               cmp_wr_en,
   input  logic [CMP_W-1:0]   cmp_wr_data,
   input  logic               ip_clr,
   output logic [CNT_W-1:0]   count_q,
   output logic [CMP_W-1:0]   scaled_q,
   output logic [CMP_W-1:0]   cmp_q,
   output logic               ip,
   output logic               oneshot_clr
);

   logic [CNT_W-1:0] r_count;
   logic [CMP_W-1:0] r_cmp;
   logic             r_ip;
   logic             r_ip_d;
   logic             r_hit_d;
   logic             r_oneshot_clr;

   logic [CMP_W-1:0] w_scaled;
   logic             w_running;
   logic             w_hit;
   logic             w_set_lvl;
   logic             w_set_new;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_ip_nxt;

   ux607_aon_scale_mux #(
      .CNT_W   (CNT_W),
      .CMP_W   (CMP_W),
      .SCALE_W (SCALE_W)
   ) u_scale_mux (
      .i_count    (r_count),
      .i_scale    (cfg_scale),
      .o_scaled_c (w_scaled)
   );

   assign w_running = cfg_en_always | cfg_en_oneshot;
   assign w_hit     = (w_scaled >= r_cmp);
   assign w_set_lvl = w_running & w_hit;
   // A hit that was not present last cycle is a fresh event and beats a same-cycle clear
   assign w_set_new = w_set_lvl & ~r_hit_d;

   // Counter next value: bus write, clear-on-compare, increment, hold
   always_comb begin
      w_cnt_nxt = r_count;
      if (cnt_wr_en) begin
         w_cnt_nxt = cnt_wr_data;
      end else if (w_running && w_hit && cfg_zero_cmp) begin
         w_cnt_nxt = '0;
      end else if (w_running) begin
         w_cnt_nxt = r_count + CNT_W'(1);
      end
   end

   // Sticky pending bit: fresh hit always sets, continuing hit re-sets unless cleared
   always_comb begin
      w_ip_nxt = w_set_new | (~ip_clr & (r_ip | w_set_lvl));
   end

   // Counter and compare registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
         r_cmp   <= '1;
      end else begin
         r_count <= w_cnt_nxt;
         if (cmp_wr_en) begin
            r_cmp <= cmp_wr_data;
         end
      end
   end

   // Interrupt pending, hit history and oneshot clear pulse
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_hit_d       <= 1'b0;
         r_ip          <= 1'b0;
         r_ip_d        <= 1'b0;
         r_oneshot_clr <= 1'b0;
      end else begin
         r_hit_d       <= w_set_lvl;
         r_ip          <= w_ip_nxt;
         r_ip_d        <= r_ip;
         r_oneshot_clr <= r_ip & ~r_ip_d & cfg_en_oneshot;
      end
   end

   assign count_q     = r_count;
   assign scaled_q    = w_scaled;
   assign cmp_q       = r_cmp;
   assign ip          = r_ip;
   assign oneshot_clr = r_oneshot_clr;

endmodule : ux607_aon_scaled_counter

// File: tb/tb_ux607_aon_scaled_counter.sv
// Directed bench for the always-on scaled counter.
module tb_ux607_aon_scaled_counter;

   logic        clock;
   logic        reset_n;
   logic [2:0]  cfg_scale;
   logic        cfg_en_always;
   logic        cfg_en_oneshot;
   logic        cfg_zero_cmp;
   logic        cnt_wr_en;
   logic [30:0] cnt_wr_data;
   logic        cmp_wr_en;
   logic [15:0] cmp_wr_data;
   logic        ip_clr;
   logic [30:0] count_q;
   logic [15:0] scaled_q;
   logic [15:0] cmp_q;
   logic        ip;
   logic        oneshot_clr;

   int tests;
   int errors;

   ux607_aon_scaled_counter dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .cfg_scale      (cfg_scale),
      .cfg_en_always  (cfg_en_always),
      .cfg_en_oneshot (cfg_en_oneshot),
      .cfg_zero_cmp   (cfg_zero_cmp),
      .cnt_wr_en      (cnt_wr_en),
      .cnt_wr_data    (cnt_wr_data),
      .cmp_wr_en      (cmp_wr_en),
      .cmp_wr_data    (cmp_wr_data),
      .ip_clr         (ip_clr),
      .count_q        (count_q),
      .scaled_q       (scaled_q),
      .cmp_q          (cmp_q),
      .ip             (ip),
      .oneshot_clr    (oneshot_clr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Hard stop in case something wedges
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance n clocks and land 1 time unit after the rising edge
   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      cfg_scale      = 3'd0;
      cfg_en_always  = 1'b0;
      cfg_en_oneshot = 1'b0;
      cfg_zero_cmp   = 1'b0;
      cnt_wr_en      = 1'b0;
      cnt_wr_data    = 31'd0;
      cmp_wr_en      = 1'b0;
      cmp_wr_data    = 16'd0;
      ip_clr         = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset_n = 1'b0;
      #3;
      reset_n = 1'b1;
      tick(1);
   endtask

   task automatic load_cmp(input logic [15:0] v);
      cmp_wr_en   = 1'b1;
      cmp_wr_data = v;
      tick(1);
      cmp_wr_en   = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset_n = 1'b0;
      #12;
      tests++; if (count_q !== 31'd0) begin errors++; $display("FAIL reset_count: got %h want %h", count_q, 31'd0); end
      tests++; if (cmp_q !== 16'hFFFF) begin errors++; $display("FAIL reset_cmp: got %h want %h", cmp_q, 16'hFFFF); end
      tests++; if (ip !== 1'b0) begin errors++; $display("FAIL reset_ip: got %b want 0", ip); end
      tests++; if (oneshot_clr !== 1'b0) begin errors++; $display("FAIL reset_oneshot_clr: got %b want 0", oneshot_clr); end
      @(negedge clock);
      reset_n = 1'b1;
      tick(1);
      tests++; if (count_q !== 31'd0) begin errors++; $display("FAIL idle_after_reset: got %h want 0", count_q); end
   endtask

   task automatic test_count_always();
      do_reset();
      load_cmp(16'd5);
      tests++; if (cmp_q !== 16'd5) begin errors++; $display("FAIL cmp_load: got %h want %h", cmp_q, 16'd5); end
      cfg_en_always = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick(1);
         tests++; if (count_q !== 31'(k)) begin errors++; $display("FAIL count_step%0d: got %0d want %0d", k, count_q, k); end
      end
      tests++; if (ip !== 1'b0) begin errors++; $display("FAIL ip_before_hit: got %b want 0", ip); end
      tick(1);
      tests++; if (count_q !== 31'd6) begin errors++; $display("FAIL count_6: got %0d want 6", count_q); end
      tests++; if (ip !== 1'b1) begin errors++; $display("FAIL ip_after_hit: got %b want 1", ip); end
      tick(3);
      tests++; if (count_q !== 31'd9) begin errors++; $display("FAIL count_9: got %0d want 9", count_q); end
      tests++; if (ip !== 1'b1) begin errors++; $display("FAIL ip_sticky: got %b want 1", ip); end
      tests++; if (oneshot_clr !== 1'b0) begin errors++; $display("FAIL no_oneshot_pulse: got %b want 0", oneshot_clr); end
      cfg_en_always = 1'b0;
      tick(1);
      tests++; if (count_q !== 31'd9) begin errors++; $display("FAIL hold_count: got %0d want 9", count_q); end
      tests++; if (ip !== 1'b1) begin errors++; $display("FAIL hold_ip: got %b want 1", ip); end
   endtask

   task automatic test_scaled_zero_cmp();
      do_reset();
      load_cmp(16'd2);
      cfg_scale     = 3'd3;
      cfg_zero_cmp  = 1'b1;
      cfg_en_always = 1'b1;
      tick(16);
      tests++; if (count_q !== 31'd16) begin errors++; $display("FAIL zc_count16: got %0d want 16", count_q); end
      tests++; if (scaled_q !== 16'd2) begin errors++; $display("FAIL zc_scaled: got %h want 2", scaled_q); end
      tests++; if (ip !== 1'b0) begin errors++; $display("FAIL zc_ip_early: got %b want 0", ip); end
      tick(1);
      tests++; if (count_q !== 31'd0) begin errors++; $display("FAIL zc_clear: got %0d want 0", count_q); end
      tests++; if (ip !== 1'b1) begin errors++; $display("FAIL zc_ip: got %b want 1", ip); end
      tick(16);
      tests++; if (count_q !== 31'd16) begin errors++; $display("FAIL zc_period_16: got %0d want 16", count_q); end
      tick(1);
      tests++; if (count_q !== 31'd0) begin errors++; $display("FAIL zc_period_0: got %0d want 0", count_q); end
   endtask

   task automatic test_oneshot();
      do_reset();
      load_cmp(16'd3);
      cfg_en_oneshot = 1'b1;
      tick(3);
      tests++; if (count_q !== 31'd3) begin errors++; $display("FAIL os_count3: got %0d want 3", count_q); end
      tests++; if (ip !== 1'b0) begin errors++; $display("FAIL os_ip_early: got %b want 0", ip); end
      tick(1);
      tests++; if (ip !== 1'b1) begin errors++; $display("FAIL os_ip: got %b want 1", ip); end
      tests++; if (oneshot_clr !== 1'b0) begin errors++; $display("FAIL os_pulse_early: got %b want 0", oneshot_clr); end
      tick(1);
      tests++; if (oneshot_clr !== 1'b1) begin errors++; $display("FAIL os_pulse: got %b want 1", oneshot_clr); end
      tests++; if (count_q !== 31'd5) begin errors++; $display("FAIL os_count5: got %0d want 5", count_q); end
      cfg_en_oneshot = 1'b0;
      tick(1);
      tests++; if (oneshot_clr !== 1'b0) begin errors++; $display("FAIL os_pulse_width: got %b want 0", oneshot_clr); end
      tests++; if (count_q !== 31'd5) begin errors++; $display("FAIL os_hold: got %0d want 5", count_q); end
      tick(1);
      tests++; if (count_q !== 31'd5) begin errors++; $display("FAIL os_hold2: got %0d want 5", count_q); end
      tests++; if (ip !== 1'b1) begin errors++; $display("FAIL os_ip_hold: got %b want 1", ip); end
   endtask

   task automatic test_ip_clr();
      do_reset();
      load_cmp(16'd3);
      cfg_en_always = 1'b1;
      tick(4);
      tests++; if (ip !== 1'b1) begin errors++; $display("FAIL clr_ip_set: got %b want 1", ip); end
      ip_clr = 1'b1;
      tick(1);
      ip_clr = 1'b0;
      tests++; if (ip !== 1'b0) begin errors++; $display("FAIL clr_ip_low: got %b want 0", ip); end
      tick(1);
      tests++; if (ip !== 1'b1) begin errors++; $display("FAIL clr_ip_reset: got %b want 1", ip); end
      cfg_en_always = 1'b0;
      cnt_wr_en     = 1'b1;
      cnt_wr_data   = 31'd0;
      tick(1);
      cnt_wr_data   = 31'd3;
      tick(1);
      cnt_wr_en     = 1'b0;
      tests++; if (count_q !== 31'd3) begin errors++; $display("FAIL clr_preload: got %0d want 3", count_q); end
      cfg_en_always = 1'b1;
      ip_clr        = 1'b1;
      tick(1);
      tests++; if (ip !== 1'b1) begin errors++; $display("FAIL clr_set_wins: got %b want 1", ip); end
      cfg_en_always = 1'b0;
      tick(1);
      ip_clr = 1'b0;
      tests++; if (ip !== 1'b0) begin errors++; $display("FAIL clr_idle_clear: got %b want 0", ip); end
      tick(1);
      tests++; if (ip !== 1'b0) begin errors++; $display("FAIL clr_no_set_idle: got %b want 0", ip); end
      tests++; if (count_q !== 31'd4) begin errors++; $display("FAIL clr_idle_count: got %0d want 4", count_q); end
   endtask

   task automatic test_wrap();
      do_reset();
      cnt_wr_en   = 1'b1;
      cnt_wr_data = 31'h7FFF_FFFF;
      tick(1);
      cnt_wr_en   = 1'b0;
      tests++; if (count_q !== 31'h7FFF_FFFF) begin errors++; $display("FAIL wr_count: got %h want 7fffffff", count_q); end
      tests++; if (scaled_q !== 16'hFFFF) begin errors++; $display("FAIL wr_scaled0: got %h want ffff", scaled_q); end
      cfg_scale = 3'd7;
      #1;
      tests++; if (scaled_q !== 16'hFFFF) begin errors++; $display("FAIL wr_scaled7: got %h want ffff", scaled_q); end
      cfg_scale     = 3'd0;
      cfg_en_always = 1'b1;
      tick(1);
      tests++; if (count_q !== 31'd0) begin errors++; $display("FAIL wrap_zero: got %h want 0", count_q); end
      tests++; if (ip !== 1'b1) begin errors++; $display("FAIL wrap_ip: got %b want 1", ip); end
      cnt_wr_en   = 1'b1;
      cnt_wr_data = 31'h7FFF_FFFF;
      tick(1);
      cfg_zero_cmp = 1'b1;
      cnt_wr_data  = 31'h00AB_CDEF;
      tick(1);
      cnt_wr_en    = 1'b0;
      tests++; if (count_q !== 31'h00AB_CDEF) begin errors++; $display("FAIL wr_beats_zero: got %h want abcdef", count_q); end
      tests++; if (scaled_q !== 16'hCDEF) begin errors++; $display("FAIL wr_scaled: got %h want cdef", scaled_q); end
      tick(1);
      tests++; if (count_q !== 31'h00AB_CDF0) begin errors++; $display("FAIL wr_then_inc: got %h want abcdf0", count_q); end
   endtask

   task automatic test_scale_change();
      do_reset();
      cnt_wr_en   = 1'b1;
      cnt_wr_data = 31'h7F12_3456;
      tick(1);
      cnt_wr_en   = 1'b0;
      tests++; if (scaled_q !== 16'h3456) begin errors++; $display("FAIL sc_scale0: got %h want 3456", scaled_q); end
      cfg_scale = 3'd7;
      #1;
      tests++; if (scaled_q !== 16'h2468) begin errors++; $display("FAIL sc_scale7: got %h want 2468", scaled_q); end
      cfg_scale = 3'd4;
      #1;
      tests++; if (scaled_q !== 16'h2345) begin errors++; $display("FAIL sc_scale4: got %h want 2345", scaled_q); end
      tests++; if (count_q !== 31'h7F12_3456) begin errors++; $display("FAIL sc_count_kept: got %h want 7f123456", count_q); end
   endtask

   task automatic test_async_reset();
      do_reset();
      load_cmp(16'd2);
      cfg_en_oneshot = 1'b1;
      tick(4);
      tests++; if (oneshot_clr !== 1'b1) begin errors++; $display("FAIL ar_pulse_pre: got %b want 1", oneshot_clr); end
      #3;
      reset_n = 1'b0;
      #1;
      tests++; if (count_q !== 31'd0) begin errors++; $display("FAIL ar_count: got %h want 0", count_q); end
      tests++; if (ip !== 1'b0) begin errors++; $display("FAIL ar_ip: got %b want 0", ip); end
      tests++; if (cmp_q !== 16'hFFFF) begin errors++; $display("FAIL ar_cmp: got %h want ffff", cmp_q); end
      tests++; if (oneshot_clr !== 1'b0) begin errors++; $display("FAIL ar_pulse: got %b want 0", oneshot_clr); end
      clear_inputs();
      reset_n = 1'b1;
      tick(1);
   endtask

   initial begin
      tests  = 0;
      errors = 0;
      test_reset();
      test_count_always();
      test_scaled_zero_cmp();
      test_oneshot();
      test_ip_clr();
      test_wrap();
      test_scale_change();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule : tb_ux607_aon_scaled_counter

// File: doc/ux607_aon_scaled_counter.md
Name: ux607_aon_scaled_counter

Overview:
Always-on scaled counter/comparator stage in the perips subsystem, directly downstream of the 5-bit async-reset config register vector. That vector holds {cfg_en_oneshot, cfg_en_always, cfg_scale[2:0]}; this block consumes those bits plus bus write strobes. It produces the running count, a scaled view, a sticky compare interrupt, and a one-cycle pulse that clears the oneshot enable bit upstream.

Parameters:
CNT_W, 31, width of the free-running counter
CMP_W, 16, width of the compare register and scaled view
SCALE_W, 3, width of the scale select (shift 0..7)

Ports:
clock  in  1  sole clock
reset_n  in  1  asynchronous, active-low reset
cfg_scale  in  SCALE_W  right-shift applied to count for the scaled view
cfg_en_always  in  1  count continuously while set
cfg_en_oneshot  in  1  count until the first compare hit
cfg_zero_cmp  in  1  clear the counter on a compare hit
cnt_wr_en  in  1  bus write strobe for the counter
cnt_wr_data  in  CNT_W  counter write value
cmp_wr_en  in  1  bus write strobe for the compare register
cmp_wr_data  in  CMP_W  compare write value
ip_clr  in  1  single-cycle clear of the interrupt pending bit
count_q  out  CNT_W  current counter value
scaled_q  out  CMP_W  count_q[cfg_scale +: CMP_W]; bits above CNT_W read 0
cmp_q  out  CMP_W  current compare value
ip  out  1  sticky compare interrupt pending
oneshot_clr  out  1  one-cycle pulse; upstream clears cfg_en_oneshot

Behaviour:
- Reset (reset_n low, asynchronous): count_q=0, cmp_q=all ones, ip=0, oneshot_clr=0, internal hit_d=0. Release is synchronous to clock, handled by the reset sync upstream.
- running = cfg_en_always | cfg_en_oneshot.
- hit (combinational) = (scaled_q >= cmp_q).
- Counter next-state priority, evaluated each clock:
  1. cnt_wr_en -> cnt_wr_data
  2. running & hit & cfg_zero_cmp -> 0
  3. running -> count_q+1, wrapping from all ones to 0
  4. otherwise hold
- cmp_wr_en loads cmp_wr_data the next cycle. The new value affects hit from that cycle on.
- ip is set the cycle after hit goes high while running; hit_d is hit registered with running.
- ip is sticky. If set and ip_clr occur in the same cycle, set wins. If hit is still asserted after ip_clr, ip re-sets the following cycle.
- oneshot_clr pulses high one cycle after a 0->1 transition of ip while cfg_en_oneshot=1. It never stays high for more than one cycle.
- With cfg_en_oneshot=0 and cfg_en_always=0, the counter holds, ip holds, and no new set occurs.
- A scale change mid-count takes effect immediately on scaled_q and hit; the count value itself is not altered.
- Reset asserted mid-operation returns everything to reset values within the same cycle (asynchronous). There is no pending-state carry-over.
- Latency: count write to count_q is 1 cycle. Compare hit to ip is 1 cycle. ip to oneshot_clr is 1 cycle.

Decomposition:
- Shared perips package holds:
  - CNT_W, CMP_W, SCALE_W defaults
  - the config bit-index constants (SCALE lsb/msb, EN_ALWAYS=3, EN_ONESHOT=4), which the upstream register vector also uses
- One sub-module, ux607_aon_scale_mux: the combinational shift/select producing scaled_q from count_q and cfg_scale, zero-extending past CNT_W.
- Counter, compare and interrupt logic stay in the top module.

Test Plan:
- Reset, then cfg_en_always=1, scale=0, cmp=5 -> count_q counts 0,1,2…; hit at count 5; ip=1 on the next cycle and stays 1 while counting continues.
- scale=3, cmp=2, zero_cmp=1, en_always=1 -> hit at count 16; count_q=0 on the next cycle; ip set; the count restarts and repeats with period 17.
- en_oneshot=1, cmp=3, scale=0 -> ip rises after count 3; oneshot_clr is a single pulse one cycle after ip rises; the model deasserts en_oneshot and count_q then holds.
- ip=1 and hit still true, pulse ip_clr -> ip=0 for one cycle, then 1 again. Apply ip_clr in the same cycle as a new set -> ip stays 1.
- Preload count=all ones (2^31-1) via cnt_wr_en, running, cmp=all ones -> count_q wraps to 0; scaled_q is computed correctly at the boundary. Same-cycle cnt_wr_en with zero_cmp hit -> the written value wins.
- Assert reset_n low mid-count with ip=1 -> count_q=0, ip=0, cmp_q=all ones, oneshot_clr=0 immediately, without waiting for a clock edge.
